// File: rtl/pipe_hazard_ctrl_pkg.sv
// pipe_hazard_ctrl_pkg: Y86-64 icode/stat/register encodings and hazard-control FSM states
package pipe_hazard_ctrl_pkg;
  localparam logic [3:0] IMRMOVQ = 4'h5;
  localparam logic [3:0] IOPQ    = 4'h6;
  localparam logic [3:0] IJXX    = 4'h7;
  localparam logic [3:0] IRET    = 4'h9;
  localparam logic [3:0] IPOPQ   = 4'hB;
  localparam logic [3:0] RNONE   = 4'hF;
  localparam logic [2:0] SAOK    = 3'd1;
  localparam logic [2:0] SHLT    = 3'd2;
  localparam logic [2:0] SADR    = 3'd3;
  localparam logic [2:0] SINS    = 3'd4;
  localparam logic [1:0] RUN     = 2'd0;
  localparam logic [1:0] DRAIN   = 2'd1;
  localparam logic [1:0] HALTED  = 2'd2;
endpackage

// File: rtl/pipe_hazard_ctrl_sat_counter.sv
// pipe_hazard_ctrl_sat_counter: saturating up-counter (clock, reset, inc -> count)
module pipe_hazard_ctrl_sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);
  always_ff @(posedge clock)
    if (reset) count <= '0;
    else if (inc && !(&count)) count <= count + CNT_W'(1);
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: Y86-64 pipeline stall/bubble control, RUN/DRAIN/HALTED sequencing and perf counters
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [3:0]       D_icode,
  input  logic [3:0]       E_icode,
  input  logic [3:0]       M_icode,
  input  logic [3:0]       E_dstM,
  input  logic [3:0]       d_srcA,
  input  logic [3:0]       d_srcB,
  input  logic             e_Cnd,
  input  logic [2:0]       m_stat,
  input  logic [2:0]       W_stat,
  output logic             F_stall,
  output logic             D_stall,
  output logic             D_bubble,
  output logic             E_bubble,
  output logic             M_bubble,
  output logic             W_stall,
  output logic             set_cc,
  output logic             halted,
  output logic [2:0]       cpu_stat,
  output logic [CNT_W-1:0] cyc_cnt,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] mispr_cnt,
  output logic [CNT_W-1:0] ret_cnt
);
  logic [1:0] state, state_nx;
  logic lu, ret, mp, exc, run, drn, hlt, w_exc;
  assign lu = (E_icode == IMRMOVQ || E_icode == IPOPQ) && E_dstM != RNONE &&
              (E_dstM == d_srcA || E_dstM == d_srcB);
  assign ret = D_icode == IRET || E_icode == IRET || M_icode == IRET;
  assign mp = E_icode == IJXX && !e_Cnd;
  assign w_exc = W_stat != SAOK;
  assign exc = m_stat != SAOK || w_exc;
  assign run = state == RUN;
  assign hlt = state == HALTED;
  assign drn = !run && !hlt;
  assign halted = hlt;
  assign F_stall = !reset && (run ? (lu || ret) : 1'b1);
  assign D_stall = !reset && (run ? lu : 1'b1);
  assign D_bubble = reset || (run && (mp || (!lu && ret)));
  assign E_bubble = reset || (run ? (mp || lu) : drn);
  assign M_bubble = reset || (run ? exc : drn);
  assign W_stall = !reset && (hlt || w_exc);
  assign set_cc = !reset && run && E_icode == IOPQ && !exc;
  assign state_nx = (!hlt && w_exc) ? HALTED : (run && m_stat != SAOK) ? DRAIN : state;
  always_ff @(posedge clock)
    if (reset) begin
      state <= RUN;
      cpu_stat <= SAOK;
    end else begin
      state <= state_nx;
      if (!hlt && w_exc) cpu_stat <= W_stat;
    end
  pipe_hazard_ctrl_sat_counter #(.CNT_W(CNT_W)) u_cyc (
    .clock(clock), .reset(reset), .inc(!hlt), .count(cyc_cnt));
  pipe_hazard_ctrl_sat_counter #(.CNT_W(CNT_W)) u_stall (
    .clock(clock), .reset(reset), .inc(run && lu), .count(stall_cnt));
  pipe_hazard_ctrl_sat_counter #(.CNT_W(CNT_W)) u_mispr (
    .clock(clock), .reset(reset), .inc(run && mp), .count(mispr_cnt));
  pipe_hazard_ctrl_sat_counter #(.CNT_W(CNT_W)) u_ret (
    .clock(clock), .reset(reset), .inc(run && !lu && ret), .count(ret_cnt));
endmodule
